// File: rtl/raytrace_pkg.sv
// Shared types and constants for the ray-trace output path: float field layout,
// default frame geometry and the RGB565 pixel format.
package raytrace_pkg;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int EXP_BIAS  = 127;
  localparam int DEF_H_RES = 1280;
  localparam int DEF_V_RES = 720;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t pack565(input logic [7:0] r8, input logic [7:0] g8,
                                      input logic [7:0] b8);
    rgb565_t p;
    p.r = r8[7:3];
    p.g = g8[7:2];
    p.b = b8[7:3];
    return p;
  endfunction
endpackage

// File: rtl/float_to_u8.sv
// Maps an IEEE-754 single in [0.0, 1.0] to an 8-bit channel value, saturating
// above 1.0 and flushing negatives, denormals and NaN to zero.
module float_to_u8 import raytrace_pkg::*; (
  input  logic [31:0] f,
  output logic [7:0]  u8
);
  logic             sign;
  logic [EXP_W-1:0] e;
  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]  sig;
  logic [4:0]       sh;

  assign sign = f[31];
  assign e    = f[MANT_W +: EXP_W];
  assign mant = f[MANT_W-1:0];
  assign sig  = {1'b1, mant};

  always_comb begin
    u8 = '0;
    sh = 5'(8'd142 - e);
    if (sign || e == '0)              u8 = '0;
    else if (e == '1)                 u8 = (mant == '0) ? 8'hFF : 8'h00;
    else if (e >= 8'(EXP_BIAS))       u8 = 8'hFF;
    else if (e < 8'(EXP_BIAS - 8))    u8 = '0;
    // 1.0 would land at bit 8, so exponents 119..126 map onto the low byte
    else                              u8 = 8'(sig >> sh);
  end
endmodule

// File: rtl/pixel_color_writer.sv
// Converts float RGB triples to RGB565, buffers them in a small FWFT FIFO and
// writes them to the frame buffer in raster order over a valid/ready port.
module pixel_color_writer import raytrace_pkg::*; #(
  parameter  int H_RES      = DEF_H_RES,
  parameter  int V_RES      = DEF_V_RES,
  parameter  int FIFO_DEPTH = 8,
  localparam int ADDR_W     = $clog2(H_RES * V_RES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [31:0]       r_in,
  input  logic [31:0]       g_in,
  input  logic [31:0]       b_in,
  input  logic              rgb_valid_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [15:0]       fb_data_out,
  output logic              fb_we_out,
  input  logic              fb_ready_in,
  output logic              frame_done_out,
  output logic              overflow_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [CNT_W:0] READY_MAX = (CNT_W+1)'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0] r8, g8, b8;
  float_to_u8 u_r (.f(r_in), .u8(r8));
  float_to_u8 u_g (.f(g_in), .u8(g8));
  float_to_u8 u_b (.f(b_in), .u8(b8));

  rgb565_t           s1_data;
  logic              s1_vld;
  rgb565_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              ready_en, overflow;
  logic              full, pop, push, last;

  assign full           = (count == FULL_CNT);
  assign fb_we_out      = (count != '0);
  assign fb_data_out    = fb_we_out ? mem[rd_ptr] : '0;
  assign pop            = fb_we_out && fb_ready_in;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push           = s1_vld && (!full || pop);
  assign last           = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  assign frame_done_out = pop && last;
  assign fb_addr_out    = addr;
  assign overflow_out   = overflow;
  assign occ            = {1'b0, count} + {{CNT_W{1'b0}}, s1_vld};
  assign ready_out      = ready_en && (occ <= READY_MAX);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rgb_valid_in;
      if (rgb_valid_in) s1_data <= pack565(r8, g8, b8);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (s1_vld && !push) overflow <= 1'b1;
    end
  end

  // running raster address avoids a y*H_RES multiply
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (pop) begin
      if (last) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (x == XW'(H_RES - 1)) begin
        x    <= '0;
        y    <= y + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        x    <= x + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end
endmodule

// File: doc/pixel_color_writer.md
Name: pixel_color_writer

Overview:
Receiving end of the `get_pixel_color` output interface (`r_out`/`g_out`/`b_out`/`rgb_valid`). Accepts IEEE-754 single-precision colour channels in [0.0, 1.0] and converts each to 8 bits. Packs the result as RGB565. Buffers pixels in a small FIFO and writes them in raster order to the frame buffer over a valid/ready write port. Sits between the shading pipeline and the frame-buffer BRAM.

Parameters:
H_RES, 1280, pixels per line
V_RES, 720, lines per frame
FIFO_DEPTH, 8, buffered pixels (power of two, >=4)
ADDR_W (localparam), $clog2(H_RES*V_RES), frame-buffer address width

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
r_in  input  32  red channel, float
g_in  input  32  green channel, float
b_in  input  32  blue channel, float
rgb_valid_in  input  1  channel triple valid this cycle
ready_out  output  1  advisory backpressure to the upstream block
fb_addr_out  output  ADDR_W  frame-buffer write address
fb_data_out  output  16  RGB565 pixel
fb_we_out  output  1  write request (valid)
fb_ready_in  input  1  frame buffer accepts the write this cycle
frame_done_out  output  1  one-cycle pulse on the last pixel of the frame
overflow_out  output  1  sticky: a sample was dropped

Behaviour:
- Reset: rst_in low → all outputs 0, FIFO empty, x/y counters 0, conversion stage invalid. ready_out rises on the first clock after release. Reset mid-write abandons the pending write.
- Float→u8 conversion, applied per channel and combinational inside stage 1:
  - sign=1, or exp=0 → 0.
  - NaN → 0. +inf → 255.
  - exp>=127 → 255 (saturate).
  - exp<119 → 0.
  - Otherwise u8 = {1,mant[22:0]} >> (142-exp), truncated.
- Packing: data = {r8[7:3], g8[7:2], b8[7:3]}.
- Stage 1: registered on rgb_valid_in. The stage-1 valid pushes the FIFO on the next cycle.
- FIFO: first-word fall-through.
  - fb_we_out = FIFO not empty.
  - fb_data_out = FIFO head.
  - Pop occurs when fb_we_out && fb_ready_in.
- Latency: input at cycle N → fb_we_out high at N+2 when the FIFO was empty.
- Handshake: while fb_we_out=1 and fb_ready_in=0, fb_addr_out and fb_data_out are held stable. The write completes on the cycle both are high.
- fb_addr_out = y*H_RES + x, kept in a registered running counter (no multiplier).
- Counter advance on each completed write:
  - x increments.
  - At x=H_RES-1: x←0, y increments.
  - At the last pixel (x=H_RES-1, y=V_RES-1): both wrap to 0, and frame_done_out pulses in the same cycle the write completes.
- ready_out = (count + stage1_valid) <= FIFO_DEPTH-2.
- Overflow: a push with the FIFO full drops the pixel and sets overflow_out. The counters do not advance for a dropped pixel. overflow_out clears only on reset.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow occurs. count is unchanged.
- rgb_valid_in in consecutive cycles is supported at full throughput while fb_ready_in=1.

Decomposition:
- Shared package `raytrace_pkg`:
  - RGB565 pixel typedef.
  - Float field-width constants (EXP_BIAS=127).
  - Default H_RES/V_RES.
- Sub-module `float_to_u8`: combinational, instantiated three times.
- FIFO is inline; a sub-module is not warranted.

Test Plan:
- r=0x3F800000 (1.0), g=0x3F000000 (0.5), b=0x00000000, fb_ready_in=1 → fb_data_out=0xFC00, fb_addr_out=0, fb_we_out at input+2 cycles.
- Channels 0x3E800000 (0.25), 0xBF000000 (-0.5), 0x40400000 (3.0) → u8 64/0/255 → 0x4000|0x0000|0x001F = 0x401F.
- Params H_RES=4, V_RES=2: stream 9 pixels with fb_ready_in=1 → addresses 0..7 then 0; frame_done_out pulses exactly once, on address 7.
- fb_ready_in=0 for 20 cycles while valid every cycle:
  - ready_out falls at count 6.
  - 8 pixels retained, later pixels dropped, overflow_out=1.
  - On release, the 8 retained pixels are written in order, addresses contiguous, fb_addr_out/fb_data_out stable while stalled.
- Assert rst_in low during a stalled write → next cycle fb_we_out=0 and overflow_out=0; after release the first pixel goes to address 0.
- NaN 0x7FC00000 and +inf 0x7F800000 on red → r8 0 and 255 respectively.
